alu_operand_issue: RTL and testbench

- Upstream issue stage for the 8-bit bitwise/arithmetic result-select datapath.
- Buffers operand bundles {x, sel, a, b} from the producer in a small first-word-fall-through FIFO.
- Presents the head bundle to the downstream select stage under a valid/ready handshake.
- Provides occupancy, a flush, and a saturating back-pressure stall counter for performance checks.

---
 rtl/alu_issue_pkg.sv | 24 ++
 rtl/alu_issue_fifo_mem.sv | 36 +++
 rtl/alu_operand_issue.sv | 115 +++++++++++
 tb/tb_alu_operand_issue.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_pkg
//  Description : Shared types and constants for the ALU operand issue stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_issue_pkg;

  // Default operand width of the select datapath.
  localparam int DEFAULT_DATA_W = 8;

  // One operand bundle as delivered to the select stage.
  typedef struct packed {
    logic                      x;
    logic                      sel;
    logic [DEFAULT_DATA_W-1:0] a;
    logic [DEFAULT_DATA_W-1:0] b;
  } bundle_t;

  // Width of a packed bundle at the default operand width.
  localparam int BUNDLE_W = $bits(bundle_t);

endpackage : alu_issue_pkg
`default_nettype wire

// File: rtl/alu_issue_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_fifo_mem
//  Description : DEPTH x WIDTH register array, one synchronous write port and
//                one asynchronous read port for the issue FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_fifo_mem
  import alu_issue_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = BUNDLE_W,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Store the incoming bundle; contents need no reset since reads are
  // qualified by occupancy in the parent.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule : alu_issue_fifo_mem
`default_nettype wire

// File: rtl/alu_operand_issue.sv
`default_nettype none
// ============================================================================
//  Module      : alu_operand_issue
//  Description : First-word-fall-through operand FIFO feeding the ALU select
//                stage, with occupancy, flush and saturating stall counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_operand_issue
  import alu_issue_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int DEPTH   = 4,
  parameter int STALL_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_x,
  input  logic                     in_sel,
  input  logic [DATA_W-1:0]        in_a,
  input  logic [DATA_W-1:0]        in_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_x,
  output logic                     out_sel,
  output logic [DATA_W-1:0]        out_a,
  output logic [DATA_W-1:0]        out_b,
  output logic [$clog2(DEPTH):0]   count,
  output logic [STALL_W-1:0]       stall_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = 2 * DATA_W + 2;

  // Reject depths the wrapping pointers cannot represent.
  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("alu_operand_issue: DEPTH must be a power of two and >= 2");
    end
  endgenerate

  logic [AW-1:0]      r_rd_ptr;
  logic [AW-1:0]      r_wr_ptr;
  logic [CW-1:0]      r_count;
  logic [STALL_W-1:0] r_stall;

  logic               w_full;
  logic               w_push;
  logic               w_pop;
  logic [BW-1:0]      w_wr_data;
  logic [BW-1:0]      w_rd_data;

  assign w_full    = (r_count == CW'(DEPTH));
  assign in_ready  = !w_full && !flush && !rst;
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign w_wr_data = {in_x, in_sel, in_a, in_b};

  alu_issue_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (BW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wr_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_data)
  );

  // Head bundle is shown only while valid so idle outputs stay at zero.
  assign {out_x, out_sel, out_a, out_b} = out_valid ? w_rd_data : '0;
  assign count     = r_count;
  assign stall_cnt = r_stall;

  // Pointer and occupancy update; flush empties the FIFO and overrides a pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // Saturating count of back-pressured cycles; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall <= '0;
    end else if (out_valid && !out_ready && (r_stall != {STALL_W{1'b1}})) begin
      r_stall <= r_stall + STALL_W'(1);
    end
  end

endmodule : alu_operand_issue
`default_nettype wire

// File: tb/tb_alu_operand_issue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_operand_issue
//  Description : Self-checking bench for alu_operand_issue, queue-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_operand_issue;
  import alu_issue_pkg::*;

  localparam int DEPTH   = 4;
  localparam int STALL_W = 4;
  localparam int STALL_MAX = (1 << STALL_W) - 1;

  logic       clk = 1'b0;
  logic       rst, flush, in_valid, in_x, in_sel, out_ready;
  logic [7:0] in_a, in_b;
  logic       in_ready, out_valid, out_x, out_sel;
  logic [7:0] out_a, out_b;
  logic [2:0] count;
  logic [STALL_W-1:0] stall_cnt;

  int n_vec = 0;
  int n_err = 0;

  bundle_t m_q[$];
  int      m_stall = 0;

  always #5 clk = ~clk;

  alu_operand_issue #(
    .DATA_W  (8),
    .DEPTH   (DEPTH),
    .STALL_W (STALL_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_sel    (in_sel),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_sel   (out_sel),
    .out_a     (out_a),
    .out_b     (out_b),
    .count     (count),
    .stall_cnt (stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic x, input logic s,
                       input logic [7:0] a, input logic [7:0] b, input logic ordy);
    in_valid  = v;
    in_x      = x;
    in_sel    = s;
    in_a      = a;
    in_b      = b;
    out_ready = ordy;
  endtask

  // One clock: compare outputs mid-cycle, then advance the model across the edge.
  task automatic cycle(input bit do_chk);
    bundle_t head;
    bundle_t nb;
    bit      exp_valid;
    bit      exp_ready;
    @(negedge clk);
    exp_valid = (m_q.size() != 0);
    exp_ready = (m_q.size() < DEPTH) && !flush && !rst;
    head      = exp_valid ? m_q[0] : '0;
    if (do_chk) begin
      chk("count",     32'(count),     32'(m_q.size()));
      chk("out_valid", 32'(out_valid), 32'(exp_valid));
      chk("in_ready",  32'(in_ready),  32'(exp_ready));
      chk("out_x",     32'(out_x),     32'(head.x));
      chk("out_sel",   32'(out_sel),   32'(head.sel));
      chk("out_a",     32'(out_a),     32'(head.a));
      chk("out_b",     32'(out_b),     32'(head.b));
      chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    end
    if (rst) begin
      m_q.delete();
      m_stall = 0;
    end else begin
      if (exp_valid && !out_ready && m_stall < STALL_MAX) m_stall++;
      if (flush) begin
        m_q.delete();
      end else begin
        nb.x = in_x; nb.sel = in_sel; nb.a = in_a; nb.b = in_b;
        if (exp_valid && out_ready) void'(m_q.pop_front());
        if (in_valid && exp_ready) m_q.push_back(nb);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 8'hAA, 8'h55, 1'b0);
    // Reset for two cycles; a bundle offered during reset must be dropped.
    cycle(1'b0);
    cycle(1'b1);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    cycle(1'b1);
    cycle(1'b1);

    // Single push into an empty FIFO with downstream ready.
    drive(1'b1, 1'b1, 1'b0, 8'h3C, 8'h0F, 1'b1);
    cycle(1'b1);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    cycle(1'b1);
    cycle(1'b1);

    // Fill to full under back-pressure, try a fifth push, then drain.
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 1'($urandom), 1'($urandom), 8'(i), 8'($urandom), 1'b0);
      cycle(1'b1);
    end
    drive(1'b1, 1'b0, 1'b1, 8'h77, 8'h66, 1'b1);
    cycle(1'b1);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1);

    // Two entries held, then ten concurrent push/pop cycles across the wrap.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 1'b0);
      cycle(1'b1);
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'($urandom), 1'($urandom), 8'(8'h10 + i), 8'($urandom), 1'b1);
      cycle(1'b1);
    end

    // Bring to three entries, then flush with a push and pop also requested.
    drive(1'b1, 1'b0, 1'b0, 8'hE3, 8'h3E, 1'b0);
    cycle(1'b1);
    drive(1'b1, 1'b1, 1'b1, 8'hF1, 8'h1F, 1'b1);
    flush = 1'b1;
    cycle(1'b1);
    flush = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    cycle(1'b1);

    // Long stall to saturate the counter, then reset in the middle of it.
    drive(1'b1, 1'b1, 1'b0, 8'hC5, 8'h5C, 1'b0);
    cycle(1'b1);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b1);
    rst = 1'b1;
    cycle(1'b1);
    rst = 1'b0;
    cycle(1'b1);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
            ($urandom_range(0, 3) != 0));
      flush = ($urandom_range(0, 31) == 0);
      rst   = ($urandom_range(0, 63) == 0);
      cycle(1'b1);
    end
    rst = 1'b0; flush = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_alu_operand_issue
`default_nettype wire
